// File: rtl/mem_wb_pkg.sv
// Shared encodings for the memory/writeback boundary: result select codes,
// load width funct3 codes and the load legality helper.
package mem_wb_pkg;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10,
    RES_RSVD = 2'b11
  } result_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // A load is illegal when its width is not naturally aligned to the byte
  // offset, or when funct3 does not name a supported load width.
  function automatic logic load_fault(input logic [2:0] funct3, input logic [1:0] offset);
    logic fault;
    case (funct3)
      F3_LB, F3_LBU: fault = 1'b0;
      F3_LH, F3_LHU: fault = offset[0];
      F3_LW:         fault = (offset != 2'b00);
      default:       fault = 1'b1;
    endcase
    return fault;
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Bundle of the M-stage inputs, the W-stage control and the W-stage outputs.
// master drives the M side and observes W; slave is the pipeline register.
interface mem_wb_stage_if;
  logic        StallW;
  logic        FlushW;
  logic        ValidM;
  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  funct3M;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM;
  logic [31:0] ReadData;
  logic [31:0] PCPlus4M;
  logic        ValidW;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        LoadFaultW;
  logic [31:0] RetireCount;

  modport master (
    output StallW, FlushW, ValidM, RegWriteM, ResultSrcM, funct3M, RdM,
           ALUResultM, ReadData, PCPlus4M,
    input  ValidW, RegWriteW, RdW, ResultW, LoadFaultW, RetireCount
  );

  modport slave (
    input  StallW, FlushW, ValidM, RegWriteM, ResultSrcM, funct3M, RdM,
           ALUResultM, ReadData, PCPlus4M,
    output ValidW, RegWriteW, RdW, ResultW, LoadFaultW, RetireCount
  );
endinterface

// File: rtl/mem_wb_stage_load_extend.sv
// Combinational load formatter: picks the byte/half addressed by the offset
// and sign- or zero-extends it according to funct3.
module load_extend
  import mem_wb_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection by byte offset (half uses only offset bit 1).
  always_comb begin
    byte_sel = word[7:0];
    case (offset)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];
  end

  // Extension by load width; unsupported widths yield 0 (the stage faults them).
  always_comb begin
    value = 32'h0;
    case (funct3)
      F3_LB:   value = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  value = {24'h0, byte_sel};
      F3_LH:   value = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  value = {16'h0, half_sel};
      F3_LW:   value = word;
      default: value = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: selects the writeback value, flags illegal loads,
// holds on stall, bubbles on flush and counts retired instructions.
module mem_wb_stage
  import mem_wb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mem_wb_stage_if.slave bus
);

  logic [31:0] load_value;
  logic        fault_m;
  logic        reg_write_m;
  logic [31:0] result_m;

  logic        valid_reg;
  logic        reg_write_reg;
  logic [4:0]  rd_reg;
  logic [31:0] result_reg;
  logic        fault_reg;
  logic [31:0] retire_count_reg;

  load_extend u_load_extend (
    .word   (bus.ReadData),
    .offset (bus.ALUResultM[1:0]),
    .funct3 (bus.funct3M),
    .value  (load_value)
  );

  // Next W contents: fault detection, result select and write qualification.
  always_comb begin
    fault_m     = (bus.ResultSrcM == RES_LOAD) && load_fault(bus.funct3M, bus.ALUResultM[1:0]);
    reg_write_m = bus.RegWriteM && bus.ValidM && !fault_m && (bus.RdM != 5'd0);
    result_m    = 32'h0;
    case (bus.ResultSrcM)
      RES_ALU:  result_m = bus.ALUResultM;
      RES_LOAD: result_m = load_value;
      RES_PC4:  result_m = bus.PCPlus4M;
      default:  result_m = 32'h0;
    endcase
    if (fault_m) begin
      result_m = 32'h0;
    end
  end

  // W registers: flush beats stall; the retire counter ignores flushes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg        <= 1'b0;
      reg_write_reg    <= 1'b0;
      rd_reg           <= 5'd0;
      result_reg       <= 32'h0;
      fault_reg        <= 1'b0;
      retire_count_reg <= 32'h0;
    end else if (bus.FlushW) begin
      valid_reg     <= 1'b0;
      reg_write_reg <= 1'b0;
      rd_reg        <= 5'd0;
      result_reg    <= 32'h0;
      fault_reg     <= 1'b0;
    end else if (!bus.StallW) begin
      valid_reg     <= bus.ValidM;
      reg_write_reg <= reg_write_m;
      rd_reg        <= bus.RdM;
      result_reg    <= result_m;
      fault_reg     <= fault_m;
      if (bus.ValidM) begin
        retire_count_reg <= retire_count_reg + 32'd1;
      end
    end
  end

  assign bus.ValidW      = valid_reg;
  assign bus.RegWriteW   = reg_write_reg;
  assign bus.RdW         = rd_reg;
  assign bus.ResultW     = result_reg;
  assign bus.LoadFaultW  = fault_reg;
  assign bus.RetireCount = retire_count_reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: load extraction, faults, result select,
// stall/flush, asynchronous reset and retire counter wrap.
module tb_mem_wb_stage;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [31:0] exp_retire;

  mem_wb_stage_if bus ();

  mem_wb_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic valid, input logic rw, input logic [1:0] src,
                       input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] data,
                       input logic [31:0] pc4);
    bus.ValidM     = valid;
    bus.RegWriteM  = rw;
    bus.ResultSrcM = src;
    bus.funct3M    = f3;
    bus.RdM        = rd;
    bus.ALUResultM = alu;
    bus.ReadData   = data;
    bus.PCPlus4M   = pc4;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_w(input string tag, input logic v, input logic rw,
                         input logic [4:0] rd, input logic [31:0] res,
                         input logic flt, input logic [31:0] ret);
    check({tag, ".ValidW"},      bus.ValidW,      v);
    check({tag, ".RegWriteW"},   bus.RegWriteW,   rw);
    check({tag, ".RdW"},         bus.RdW,         rd);
    check({tag, ".ResultW"},     bus.ResultW,     res);
    check({tag, ".LoadFaultW"},  bus.LoadFaultW,  flt);
    check({tag, ".RetireCount"}, bus.RetireCount, ret);
    $display("txn %s: V=%0b RW=%0b Rd=%0d Res=%08h F=%0b Ret=%08h",
             tag, bus.ValidW, bus.RegWriteW, bus.RdW, bus.ResultW, bus.LoadFaultW, bus.RetireCount);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    exp_retire = 0;
    rst        = 1'b0;
    bus.StallW = 1'b0;
    bus.FlushW = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);

    #2;
    check_w("reset", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Loads
    drive(1, 1, 2'b01, 3'b000, 5'd5, 32'h0000_000C, 32'h80FF_7F01, 32'h0);
    cyc(); exp_retire++;
    check_w("lb_off0", 1, 1, 5'd5, 32'h0000_0001, 0, exp_retire);

    drive(1, 1, 2'b01, 3'b000, 5'd6, 32'h0000_000F, 32'h80FF_7F01, 32'h0);
    cyc(); exp_retire++;
    check_w("lb_off3", 1, 1, 5'd6, 32'hFFFF_FF80, 0, exp_retire);

    drive(1, 1, 2'b01, 3'b100, 5'd7, 32'h0000_000F, 32'h80FF_7F01, 32'h0);
    cyc(); exp_retire++;
    check_w("lbu_off3", 1, 1, 5'd7, 32'h0000_0080, 0, exp_retire);

    drive(1, 1, 2'b01, 3'b000, 5'd7, 32'h0000_0001, 32'h80FF_7F01, 32'h0);
    cyc(); exp_retire++;
    check_w("lb_off1", 1, 1, 5'd7, 32'h0000_007F, 0, exp_retire);

    drive(1, 1, 2'b01, 3'b001, 5'd8, 32'h0000_0102, 32'h8001_ABCD, 32'h0);
    cyc(); exp_retire++;
    check_w("lh_off2", 1, 1, 5'd8, 32'hFFFF_8001, 0, exp_retire);

    drive(1, 1, 2'b01, 3'b101, 5'd9, 32'h0000_0100, 32'h8001_ABCD, 32'h0);
    cyc(); exp_retire++;
    check_w("lhu_off0", 1, 1, 5'd9, 32'h0000_ABCD, 0, exp_retire);

    drive(1, 1, 2'b01, 3'b010, 5'd10, 32'h0000_0200, 32'h1234_5678, 32'h0);
    cyc(); exp_retire++;
    check_w("lw_off0", 1, 1, 5'd10, 32'h1234_5678, 0, exp_retire);

    // Faulting loads still retire
    drive(1, 1, 2'b01, 3'b010, 5'd11, 32'h0000_0201, 32'h1234_5678, 32'h0);
    cyc(); exp_retire++;
    check_w("lw_off1_fault", 1, 0, 5'd11, 32'h0, 1, exp_retire);

    drive(1, 1, 2'b01, 3'b001, 5'd12, 32'h0000_0203, 32'h1234_5678, 32'h0);
    cyc(); exp_retire++;
    check_w("lh_off3_fault", 1, 0, 5'd12, 32'h0, 1, exp_retire);

    drive(1, 1, 2'b01, 3'b011, 5'd13, 32'h0000_0200, 32'h1234_5678, 32'h0);
    cyc(); exp_retire++;
    check_w("f3_011_fault", 1, 0, 5'd13, 32'h0, 1, exp_retire);

    // Misaligned address on a non-load is not a fault
    drive(1, 1, 2'b00, 3'b010, 5'd14, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_1004);
    cyc(); exp_retire++;
    check_w("alu", 1, 1, 5'd14, 32'hDEAD_BEEF, 0, exp_retire);

    drive(1, 1, 2'b10, 3'b000, 5'd15, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_1004);
    cyc(); exp_retire++;
    check_w("pc4", 1, 1, 5'd15, 32'h0000_1004, 0, exp_retire);

    drive(1, 1, 2'b11, 3'b000, 5'd16, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_1004);
    cyc(); exp_retire++;
    check_w("rsvd", 1, 1, 5'd16, 32'h0, 0, exp_retire);

    drive(1, 1, 2'b00, 3'b000, 5'd0, 32'h0000_0055, 32'h0, 32'h0);
    cyc(); exp_retire++;
    check_w("rd0", 1, 0, 5'd0, 32'h0000_0055, 0, exp_retire);

    drive(0, 1, 2'b00, 3'b000, 5'd3, 32'h0000_0066, 32'h0, 32'h0);
    cyc();
    check_w("bubble", 0, 0, 5'd3, 32'h0000_0066, 0, exp_retire);

    // Stall: capture one instruction then hold it for three cycles
    drive(1, 1, 2'b00, 3'b000, 5'd20, 32'hCAFE_0001, 32'h0, 32'h0);
    cyc(); exp_retire++;
    check_w("pre_stall", 1, 1, 5'd20, 32'hCAFE_0001, 0, exp_retire);
    bus.StallW = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 2'b10, 3'b000, 5'(21 + i), 32'h0, 32'h0, 32'h0000_2000 + 32'(i));
      cyc();
      check_w($sformatf("stall%0d", i), 1, 1, 5'd20, 32'hCAFE_0001, 0, exp_retire);
    end

    // Flush together with stall: flush wins
    bus.FlushW = 1'b1;
    cyc();
    check_w("flush_stall", 0, 0, 5'd0, 32'h0, 0, exp_retire);
    bus.FlushW = 1'b0;
    bus.StallW = 1'b0;

    // Asynchronous reset during a stall discards the held instruction
    drive(1, 1, 2'b00, 3'b000, 5'd25, 32'h0BAD_F00D, 32'h0, 32'h0);
    cyc(); exp_retire++;
    check_w("pre_reset", 1, 1, 5'd25, 32'h0BAD_F00D, 0, exp_retire);
    bus.StallW = 1'b1;
    #2 rst = 1'b0;
    #1;
    check_w("async_reset", 0, 0, 5'd0, 32'h0, 0, 32'h0);
    exp_retire = 0;
    @(negedge clk);
    rst = 1'b1;
    cyc();
    check_w("post_reset_stall", 0, 0, 5'd0, 32'h0, 0, exp_retire);
    bus.StallW = 1'b0;
    drive(1, 1, 2'b00, 3'b000, 5'd26, 32'h0000_0AAA, 32'h0, 32'h0);
    cyc(); exp_retire++;
    check_w("first_after_reset", 1, 1, 5'd26, 32'h0000_0AAA, 0, 32'h1);

    // Retire counter wrap
    force dut.retire_count_reg = 32'hFFFF_FFFF;
    #1 release dut.retire_count_reg;
    drive(1, 1, 2'b00, 3'b000, 5'd27, 32'h0000_0BBB, 32'h0, 32'h0);
    cyc();
    check_w("wrap", 1, 1, 5'd27, 32'h0000_0BBB, 0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
